// File: rtl/fifo_control_fsm.sv
// Pointer/flag controller for a 2^ADDR_WIDTH-entry FIFO RAM: accepts, addresses, occupancy and raw full/empty.
// Enables are combinational from requests; count, flags and overflow/underflow pulses register on the edge.
module fifo_control_fsm #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  Clear,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  in_full,
    output logic                  in_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH_I    = 1 << ADDR_WIDTH;
    localparam int                DEPTH_M1_I = DEPTH_I - 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_M1 = DEPTH_M1_I[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY  = 2'b00,
        S_NORMAL = 2'b01,
        S_FULL   = 2'b10
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Clear gates the enables so the RAM sees no write while reset is held.
    assign w_wr_acc     = wr_req & (r_state != S_FULL)  & ~Clear;
    assign w_rd_acc     = rd_req & (r_state != S_EMPTY) & ~Clear;
    assign w_count_next = r_count + {{ADDR_WIDTH{1'b0}}, w_wr_acc}
                                  - {{ADDR_WIDTH{1'b0}}, w_rd_acc};

    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            r_state  <= S_EMPTY;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, w_wr_acc};
            r_rd_ptr <= r_rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, w_rd_acc};
            r_count  <= w_count_next;
            r_ovf    <= wr_req & (r_state == S_FULL);
            r_unf    <= rd_req & (r_state == S_EMPTY);
            case (r_state)
                S_EMPTY: begin
                    if (w_wr_acc) begin
                        r_state <= S_NORMAL;
                        r_empty <= 1'b0;
                    end
                end
                S_NORMAL: begin
                    if (w_wr_acc && !w_rd_acc && r_count == DEPTH_M1) begin
                        r_state <= S_FULL;
                        r_full  <= 1'b1;
                    end else if (w_rd_acc && !w_wr_acc && r_count == ONE) begin
                        r_state <= S_EMPTY;
                        r_empty <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (w_rd_acc) begin
                        r_state <= S_NORMAL;
                        r_full  <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty FIFO.
                    r_state  <= S_EMPTY;
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                    r_full   <= 1'b0;
                    r_empty  <= 1'b1;
                    r_ovf    <= 1'b0;
                    r_unf    <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en     = w_wr_acc;
    assign rd_en     = w_rd_acc;
    assign wr_addr   = r_wr_ptr;
    assign rd_addr   = r_rd_ptr;
    assign count     = r_count;
    assign in_full   = r_full;
    assign in_empty  = r_empty;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_fifo_control_fsm.sv
// Directed bench for fifo_control_fsm: occupancy-level model compared every cycle plus literal checkpoints.
module tb_fifo_control_fsm;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          Clear;
    logic          wr_req;
    logic          rd_req;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   count;
    logic          in_full;
    logic          in_empty;
    logic          overflow;
    logic          underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: occupancy and pointer positions as plain integers.
    int m_cnt = 0;
    int m_wp  = 0;
    int m_rp  = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    fifo_control_fsm #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .Clear     (Clear),
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .count     (count),
        .in_full   (in_full),
        .in_empty  (in_empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge Clear) begin
        if (Clear) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
        end else begin
            bit wa, ra;
            wa    = wr_req && (m_cnt < DEPTH);
            ra    = rd_req && (m_cnt > 0);
            m_ovf = wr_req && (m_cnt == DEPTH);
            m_unf = rd_req && (m_cnt == 0);
            m_cnt = m_cnt + int'(wa) - int'(ra);
            m_wp  = (m_wp + int'(wa)) % DEPTH;
            m_rp  = (m_rp + int'(ra)) % DEPTH;
        end
    end

    always @(negedge clk) begin
        check("cyc_wr_en",     32'(wr_en),     32'(!Clear && wr_req && m_cnt != DEPTH));
        check("cyc_rd_en",     32'(rd_en),     32'(!Clear && rd_req && m_cnt != 0));
        check("cyc_wr_addr",   32'(wr_addr),   32'(m_wp));
        check("cyc_rd_addr",   32'(rd_addr),   32'(m_rp));
        check("cyc_count",     32'(count),     32'(m_cnt));
        check("cyc_in_full",   32'(in_full),   32'(m_cnt == DEPTH));
        check("cyc_in_empty",  32'(in_empty),  32'(m_cnt == 0));
        check("cyc_overflow",  32'(overflow),  32'(m_ovf));
        check("cyc_underflow", 32'(underflow), 32'(m_unf));
    end

    task automatic step(input logic w, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            wr_req = w;
            rd_req = r;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        Clear  = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        #1;
        step(1'b1, 1'b1, 3);
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_rd_en",    32'(rd_en),    32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_in_empty", 32'(in_empty), 32'd1);
        check("rst_in_full",  32'(in_full),  32'd0);
        Clear = 1'b0;

        step(1'b1, 1'b0, 16);
        check("fill_count",   32'(count),   32'd16);
        check("fill_full",    32'(in_full), 32'd1);
        check("fill_wr_addr", 32'(wr_addr), 32'd0);
        wr_req = 1'b1; rd_req = 1'b0; #1;
        check("ovf_wr_en", 32'(wr_en), 32'd0);
        @(posedge clk); #1;
        check("ovf_pulse",   32'(overflow), 32'd1);
        check("ovf_wr_addr", 32'(wr_addr),  32'd0);
        step(1'b0, 1'b0, 1);
        check("ovf_clear", 32'(overflow), 32'd0);

        step(1'b0, 1'b1, 16);
        check("drain_empty",   32'(in_empty), 32'd1);
        check("drain_rd_addr", 32'(rd_addr),  32'd0);
        wr_req = 1'b0; rd_req = 1'b1; #1;
        check("unf_rd_en", 32'(rd_en), 32'd0);
        @(posedge clk); #1;
        check("unf_pulse", 32'(underflow), 32'd1);
        check("unf_count", 32'(count),     32'd0);
        step(1'b0, 1'b0, 1);

        step(1'b1, 1'b0, 5);
        step(1'b1, 1'b1, 20);
        check("sim_count",   32'(count),   32'd5);
        check("sim_wr_addr", 32'(wr_addr), 32'd9);
        check("sim_rd_addr", 32'(rd_addr), 32'd4);

        step(1'b1, 1'b0, 11);
        check("full2_flag", 32'(in_full), 32'd1);
        step(1'b1, 1'b1, 1);
        check("simfull_count",   32'(count),    32'd15);
        check("simfull_ovf",     32'(overflow), 32'd1);
        check("simfull_wr_addr", 32'(wr_addr),  32'd4);
        check("simfull_rd_addr", 32'(rd_addr),  32'd5);
        step(1'b1, 1'b0, 1);
        check("c15_to_full", 32'(in_full), 32'd1);

        step(1'b0, 1'b1, 15);
        check("c1_count", 32'(count), 32'd1);
        step(1'b1, 1'b1, 1);
        check("c1_both_count", 32'(count),    32'd1);
        check("c1_both_empty", 32'(in_empty), 32'd0);
        step(1'b0, 1'b1, 1);
        check("c1_to_empty", 32'(in_empty), 32'd1);
        step(1'b1, 1'b1, 1);
        check("simempty_count", 32'(count),     32'd1);
        check("simempty_unf",   32'(underflow), 32'd1);

        step(1'b1, 1'b0, 8);
        check("pre_clear_count", 32'(count), 32'd9);
        #3;
        Clear = 1'b1;
        #1;
        check("midclr_count",   32'(count),    32'd0);
        check("midclr_wr_addr", 32'(wr_addr),  32'd0);
        check("midclr_rd_addr", 32'(rd_addr),  32'd0);
        check("midclr_empty",   32'(in_empty), 32'd1);
        check("midclr_wr_en",   32'(wr_en),    32'd0);
        step(1'b0, 1'b0, 1);
        Clear  = 1'b0;
        wr_req = 1'b1;
        rd_req = 1'b0;
        #1;
        check("post_wr_en",   32'(wr_en),   32'd1);
        check("post_wr_addr", 32'(wr_addr), 32'd0);
        @(posedge clk); #1;
        check("post_wr_addr1", 32'(wr_addr), 32'd1);
        check("post_count",    32'(count),   32'd1);
        step(1'b0, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
